// File: rtl/seq_det_ctrl.sv
// Session controller for a bit-serial 1110010 sequence detector: serialises
// handshaked words MSB-first, gates the detector reset and counts its hits.
module seq_det_ctrl #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [CNT_W-1:0]  max_hits,
  input  logic [DATA_W-1:0] byte_data,
  input  logic              byte_last,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              det_in,
  output logic              det_rst_n,
  input  logic              det_out,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [CNT_W-1:0]  hit_cnt
);

  localparam int unsigned IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_SHIFT,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t             state, next_state;
  logic [DATA_W-1:0]  shreg;
  logic [IDX_W-1:0]   bit_idx;
  logic               last_seen;
  logic [CNT_W-1:0]   lim;
  logic               boundary, hit_stop, count_en, set_err, load;
  logic [CNT_W:0]     hit_next;

  always_comb begin
    next_state = state;
    byte_ready = 1'b0;
    set_err    = 1'b0;
    boundary   = (state == S_SHIFT) && (bit_idx == '0);
    hit_next   = {1'b0, hit_cnt} + (CNT_W+1)'(1);
    hit_stop   = (lim != '0) && det_out && (hit_next >= {1'b0, lim});
    // abort freezes the counter in the cycle it takes effect
    count_en   = ((state == S_SHIFT) || (state == S_DRAIN)) && det_out && !abort;
    det_in     = (state == S_SHIFT) ? shreg[DATA_W-1] : 1'b0;
    busy       = (state != S_IDLE);
    done       = (state == S_DONE);

    case (state)
      S_IDLE: begin
        if (start) next_state = S_ARM;
      end
      S_ARM: begin
        if (abort) begin
          next_state = S_IDLE;
        end else begin
          byte_ready = 1'b1;
          if (byte_valid) next_state = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (abort) begin
          next_state = S_IDLE;
        end else if (boundary) begin
          byte_ready = !last_seen && !hit_stop;
          if (byte_valid && byte_ready) next_state = S_SHIFT;
          else if (last_seen)           next_state = S_DRAIN;
          else if (hit_stop)            next_state = S_DONE;
          else begin
            next_state = S_DONE;
            set_err    = 1'b1;
          end
        end else if (hit_stop) begin
          next_state = S_DONE;
        end
      end
      S_DRAIN: next_state = abort ? S_IDLE : S_DONE;
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase

    load = byte_valid && byte_ready;
  end

  // det_rst_n tracks the next state so the detector leaves reset on the
  // same edge that presents the first bit
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      det_rst_n <= 1'b0;
    end else begin
      state     <= next_state;
      det_rst_n <= (next_state == S_SHIFT) || (next_state == S_DRAIN);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg     <= '0;
      bit_idx   <= '0;
      last_seen <= 1'b0;
      lim       <= '0;
      hit_cnt   <= '0;
      err       <= 1'b0;
    end else begin
      if ((state == S_IDLE) && start) begin
        lim       <= max_hits;
        hit_cnt   <= '0;
        err       <= 1'b0;
        last_seen <= 1'b0;
      end
      if (load) begin
        shreg     <= byte_data;
        last_seen <= byte_last;
        bit_idx   <= IDX_W'(DATA_W - 1);
      end else if (state == S_SHIFT) begin
        shreg   <= shreg << 1;
        bit_idx <= bit_idx - IDX_W'(1);
      end
      if (set_err) err <= 1'b1;
      if (count_en && (hit_cnt != '1)) hit_cnt <= hit_next[CNT_W-1:0];
    end
  end

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Bench for seq_det_ctrl: behavioural 1110010 detector plus a bit-stream
// session model that predicts hits, end cycle, consumption and error.
module tb_seq_det_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] max_hits = '0;
  logic [7:0] byte_data = '0;
  logic       byte_last = 1'b0;
  logic       byte_valid = 1'b0;
  logic       byte_ready, det_in, det_rst_n, det_out, busy, done, err;
  logic [7:0] hit_cnt;
  logic [5:0] win;

  int checks = 0;
  int failures = 0;

  seq_det_ctrl #(.DATA_W(8), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .max_hits(max_hits), .byte_data(byte_data), .byte_last(byte_last),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .det_in(det_in),
    .det_rst_n(det_rst_n), .det_out(det_out), .busy(busy), .done(done),
    .err(err), .hit_cnt(hit_cnt)
  );

  always #5 clk = ~clk;

  // Detector: registered hit when the last seven bits read 1110010
  always @(posedge clk or negedge det_rst_n) begin
    if (!det_rst_n) begin
      win     <= '0;
      det_out <= 1'b0;
    end else begin
      win     <= {win[4:0], det_in};
      det_out <= ({win, det_in} == 7'b1110010);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic bit bit_at(input bit [7:0] q[$], input int c);
    bit [7:0] b;
    b = q[c / 8];
    return b[7 - (c % 8)];
  endfunction

  // Detector output in session cycle c reflects bits c-7 .. c-1
  function automatic bit hit(input bit [7:0] q[$], input int c);
    bit [6:0] p;
    p = 7'b1110010;
    if (c < 7) return 1'b0;
    for (int i = 0; i < 7; i++)
      if (bit_at(q, c - 7 + i) != p[6 - i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic void model(input bit [7:0] q[$], input bit lastf, input int lim,
                                output int cnt, output bit xerr, output int cons,
                                output int cend, output bit drain);
    int n, c;
    bit h, stp;
    n = q.size();
    cnt = 0; xerr = 1'b0; cons = 0; cend = 0; drain = 1'b0;
    for (int j = 0; j < n; j++) begin
      for (int b = 0; b < 8; b++) begin
        c   = 8 * j + b;
        h   = hit(q, c);
        stp = (lim != 0) && h && (cnt + 1 >= lim);
        if (h && cnt < 255) cnt++;
        if (b < 7) begin
          if (stp) begin cend = c; cons = j + 1; return; end
        end else begin
          cons = j + 1;
          if (lastf && j == n - 1) begin
            if (hit(q, c + 1) && cnt < 255) cnt++;
            cend = c + 1; drain = 1'b1; return;
          end
          if (stp) begin cend = c; return; end
          if (j == n - 1) begin xerr = 1'b1; cend = c; return; end
        end
      end
    end
  endfunction

  task automatic go_start(input int lim);
    step(); start = 1'b1; max_hits = 8'(lim);
    step(); start = 1'b0; max_hits = 8'($urandom);
  endtask

  task automatic run_session(input string tag, input bit [7:0] q[$], input bit lastf,
                             input int lim, input int arm_delay);
    int  ecnt, econs, eend, n, k, rel, cyc, budget, din_err, done_rel, last_shift;
    bit  eerr, edrain, got_done, exp_din;
    model(q, lastf, lim, ecnt, eerr, econs, eend, edrain);
    n = q.size();
    last_shift = edrain ? eend - 1 : eend;
    budget = arm_delay + 8 * n + 20;
    k = 0; rel = -1; cyc = 0; din_err = 0; got_done = 1'b0; done_rel = -1;
    go_start(lim);
    while (!got_done && cyc < budget) begin
      byte_valid = (k < n) && (cyc >= arm_delay);
      byte_data  = (k < n) ? q[k] : 8'($urandom);
      byte_last  = lastf && (k == n - 1);
      @(negedge clk);
      if (rel == 0) begin
        chk($sformatf("%s_det_rst_n_shift", tag), det_rst_n, 1);
        chk($sformatf("%s_busy", tag), busy, 1);
      end
      if (rel >= 0) begin
        exp_din = (rel <= last_shift) ? bit_at(q, rel) : 1'b0;
        if (det_in !== exp_din) din_err++;
      end
      if (done === 1'b1) begin
        got_done = 1'b1;
        done_rel = rel;
      end else begin
        if (rel >= 0) rel++;
        if (byte_valid && byte_ready) begin
          if (k == 0) rel = 0;
          k++;
        end
        cyc++;
        step();
      end
    end
    chk($sformatf("%s_done_seen", tag), got_done, 1);
    chk($sformatf("%s_done_cycle", tag), done_rel, eend + 1);
    chk($sformatf("%s_hit_cnt", tag), hit_cnt, ecnt);
    chk($sformatf("%s_err", tag), err, eerr);
    chk($sformatf("%s_consumed", tag), k, econs);
    chk($sformatf("%s_det_rst_n_done", tag), det_rst_n, 0);
    chk($sformatf("%s_det_in_mismatches", tag), din_err, 0);
    step(); byte_valid = 1'b0;
    @(negedge clk);
    chk($sformatf("%s_done_pulse_end", tag), done, 0);
    chk($sformatf("%s_idle", tag), busy, 0);
    chk($sformatf("%s_hit_cnt_held", tag), hit_cnt, ecnt);
    chk($sformatf("%s_err_held", tag), err, eerr);
  endtask

  task automatic abort_case(input string tag, input bit [7:0] b, input bit lastf,
                            input int at, input int exp_cnt);
    go_start(0);
    byte_data = b; byte_last = lastf; byte_valid = 1'b1;
    @(negedge clk);
    chk($sformatf("%s_arm_ready", tag), byte_ready, 1);
    step(); byte_valid = 1'b0;
    repeat (at) step();
    abort = 1'b1;
    @(negedge clk);
    chk($sformatf("%s_ready_on_abort", tag), byte_ready, 0);
    step(); abort = 1'b0;
    @(negedge clk);
    chk($sformatf("%s_busy", tag), busy, 0);
    chk($sformatf("%s_no_done", tag), done, 0);
    chk($sformatf("%s_det_rst_n", tag), det_rst_n, 0);
    chk($sformatf("%s_hit_cnt", tag), hit_cnt, exp_cnt);
    step();
    @(negedge clk);
    chk($sformatf("%s_no_done_later", tag), done, 0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk($sformatf("%s_byte_ready", tag), byte_ready, 0);
    chk($sformatf("%s_det_in", tag), det_in, 0);
    chk($sformatf("%s_det_rst_n", tag), det_rst_n, 0);
    chk($sformatf("%s_busy", tag), busy, 0);
    chk($sformatf("%s_done", tag), done, 0);
    chk($sformatf("%s_err", tag), err, 0);
    chk($sformatf("%s_hit_cnt", tag), hit_cnt, 0);
  endtask

  initial begin
    bit [7:0] q[$];
    bit [7:0] picks [6];
    int       n, sel;
    picks = '{8'hE4, 8'h72, 8'h0E, 8'h40, 8'h39, 8'h00};

    #12;
    chk_reset_vals("reset");
    step(); reset = 1'b1;

    q = {8'hE4};               run_session("t1", q, 1'b1, 0, 0);
    q = {8'hE4, 8'hE4};        run_session("t2", q, 1'b1, 0, 1);
    q = {8'hFF};               run_session("t3", q, 1'b0, 0, 0);
    q = {8'hE4, 8'hE4, 8'hE4}; run_session("t4", q, 1'b1, 1, 0);
    q = {8'hE4, 8'h72, 8'h72}; run_session("midstop", q, 1'b1, 2, 0);

    abort_case("t5_abort_shift", 8'hE4, 1'b1, 2, 0);
    abort_case("abort_drain", 8'hE4, 1'b1, 8, 1);
    go_start(0);
    @(negedge clk);
    chk("restart_clears_hit_cnt", hit_cnt, 0);
    chk("restart_ready", byte_ready, 1);
    abort = 1'b1;
    step(); abort = 1'b0;
    @(negedge clk);
    chk("abort_arm_idle", busy, 0);

    go_start(0);
    byte_data = 8'hE4; byte_last = 1'b1; byte_valid = 1'b1;
    step(); byte_valid = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    #1;
    chk_reset_vals("t6_mid_reset");
    step(); reset = 1'b1;
    q = {8'hE4};               run_session("t6_after", q, 1'b1, 0, 0);

    for (int i = 0; i < 30; i++) begin
      q = {};
      n = $urandom_range(1, 5);
      for (int j = 0; j < n; j++) begin
        sel = $urandom_range(0, 6);
        q.push_back((sel == 6) ? 8'($urandom) : picks[sel]);
      end
      run_session($sformatf("rnd%0d", i), q, ($urandom_range(0, 3) != 0),
                  $urandom_range(0, 3), $urandom_range(0, 2));
    end

    q = {};
    for (int j = 0; j < 260; j++) q.push_back(8'hE4);
    run_session("saturate", q, 1'b1, 0, 0);
    run_session("lim255", q, 1'b1, 255, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
